// File: rtl/shift_add_multiplier.sv
// Sequential shift-add multiplier: one conditional add and 33-bit right shift per cycle.
// Signed operands are reduced to magnitudes and the sign is applied once at the end.
module shift_add_multiplier #(
    parameter int unsigned WIDTH = 16
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 start,
    input  logic                 sgn,
    input  logic [WIDTH-1:0]     a,
    input  logic [WIDTH-1:0]     b,
    output logic                 busy,
    output logic                 done,
    output logic [2*WIDTH-1:0]   p
);
    localparam int unsigned CW = $clog2(WIDTH);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        FIX  = 2'd2,
        DONE = 2'd3
    } state_t;

    state_t           state, state_nx;
    logic [WIDTH-1:0] hi, lo, mcand;
    logic             neg;
    logic [CW-1:0]    cnt;
    logic             accept;
    logic [WIDTH-1:0] a_mag, b_mag;
    logic [WIDTH:0]   sum;

    // DONE also accepts a new start so back-to-back operations run every 18 cycles.
    assign accept = start && ((state == IDLE) || (state == DONE));

    always_comb begin
        a_mag = (sgn && a[WIDTH-1]) ? (~a + 1'b1) : a;
        b_mag = (sgn && b[WIDTH-1]) ? (~b + 1'b1) : b;
        sum   = {1'b0, hi} + (lo[0] ? {1'b0, mcand} : '0);
    end

    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        busy     = 1'b0;
        done     = 1'b0;
        case (state)
            IDLE: if (accept) state_nx = RUN;
            RUN: begin
                busy = 1'b1;
                if (cnt == CW'(WIDTH - 1)) state_nx = FIX;
            end
            FIX: begin
                busy     = 1'b1;
                state_nx = DONE;
            end
            DONE: begin
                done     = 1'b1;
                state_nx = accept ? RUN : IDLE;
            end
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            hi    <= '0;
            lo    <= '0;
            mcand <= '0;
            neg   <= 1'b0;
            cnt   <= '0;
            p     <= '0;
        end else begin
            if (accept) begin
                mcand <= a_mag;
                lo    <= b_mag;
                hi    <= '0;
                cnt   <= '0;
                neg   <= sgn & (a[WIDTH-1] ^ b[WIDTH-1]);
            end else if (state == RUN) begin
                {hi, lo} <= {sum, lo[WIDTH-1:1]};
                cnt      <= cnt + 1'b1;
            end
            if (state == FIX) begin
                p <= neg ? (~{hi, lo} + 1'b1) : {hi, lo};
            end
        end
    end
endmodule

// File: tb/tb_shift_add_multiplier.sv
// Self-checking bench for shift_add_multiplier: directed cases plus a randomised
// regression compared against a plain-arithmetic reference product.
module tb_shift_add_multiplier;
    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic        sgn;
    logic [15:0] a, b;
    logic        busy, done;
    logic [31:0] p;

    int unsigned n_checks = 0;
    int unsigned n_errors = 0;

    shift_add_multiplier #(.WIDTH(16)) dut (
        .clk   (clk),
        .rst   (rst),
        .start (start),
        .sgn   (sgn),
        .a     (a),
        .b     (b),
        .busy  (busy),
        .done  (done),
        .p     (p)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s got %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] ref_mul(input logic [15:0] x, input logic [15:0] y,
                                            input logic s);
        longint prod;
        if (s) prod = longint'($signed(x)) * longint'($signed(y));
        else   prod = longint'({16'h0, x}) * longint'({16'h0, y});
        return prod[31:0];
    endfunction

    // Issues start now; returns #1 after the done edge so a following call lands on edge k+18.
    task automatic run_op(input logic [15:0] x, input logic [15:0] y, input logic s,
                          input string tag);
        logic [31:0] p_prev;
        int          lat, busy_cnt;
        logic        p_moved, overlap;
        p_prev   = p;
        a        = x;
        b        = y;
        sgn      = s;
        start    = 1'b1;
        @(posedge clk);
        #1;
        start    = 1'b0;
        a        = $urandom;
        b        = $urandom;
        busy_cnt = busy ? 1 : 0;
        lat      = 0;
        p_moved  = 1'b0;
        overlap  = 1'b0;
        for (int c = 1; c <= 40; c++) begin
            @(posedge clk);
            #1;
            if (busy && done) overlap = 1'b1;
            if (done) begin
                lat = c;
                break;
            end
            if (busy) busy_cnt++;
            if (p !== p_prev) p_moved = 1'b1;
        end
        check({tag, "_latency"}, 32'(lat), 32'd17);
        check({tag, "_busy_cycles"}, 32'(busy_cnt), 32'd17);
        check({tag, "_p_held"}, {31'b0, p_moved}, 32'd0);
        check({tag, "_busy_done_overlap"}, {31'b0, overlap}, 32'd0);
        check({tag, "_p"}, p, ref_mul(x, y, s));
    endtask

    initial begin
        int dones;
        logic [15:0] ra, rb;
        logic        rs;

        rst   = 1'b1;
        start = 1'b0;
        sgn   = 1'b0;
        a     = '0;
        b     = '0;
        repeat (3) @(posedge clk);
        #1;
        check("reset_busy", {31'b0, busy}, 32'd0);
        check("reset_done", {31'b0, done}, 32'd0);
        check("reset_p", p, 32'h0);
        rst = 1'b0;
        @(posedge clk);
        #1;

        run_op(16'd3, 16'd5, 1'b0, "u_3x5");
        check("u_3x5_const", p, 32'h0000000F);
        run_op(16'hFFFF, 16'hFFFF, 1'b0, "u_max");
        check("u_max_const", p, 32'hFFFE0001);
        run_op(16'hFFFD, 16'h0007, 1'b1, "s_m3x7");
        check("s_m3x7_const", p, 32'hFFFFFFEB);
        run_op(16'hFFFF, 16'hFFFF, 1'b1, "s_m1xm1");
        check("s_m1xm1_const", p, 32'h00000001);
        run_op(16'h8000, 16'h8000, 1'b1, "s_min");
        check("s_min_const", p, 32'h40000000);
        run_op(16'h0000, 16'h8001, 1'b1, "s_zero_a");
        run_op(16'hFFF0, 16'h0000, 1'b1, "s_zero_b");

        // Restarts during RUN (edge k+5) and FIX (edge k+17) must be ignored.
        repeat (2) @(posedge clk);
        #1;
        a = 16'd2; b = 16'd2; sgn = 1'b0; start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        dones = 0;
        for (int c = 1; c <= 40; c++) begin
            if (c == 5 || c == 17) begin
                a = 16'd9; b = 16'd9; start = 1'b1;
            end
            @(posedge clk);
            #1;
            start = 1'b0;
            if (done) dones++;
        end
        check("busy_start_dones", 32'(dones), 32'd1);
        check("busy_start_p", p, 32'd4);
        check("busy_start_idle", {31'b0, busy}, 32'd0);

        // Reset mid-RUN discards the operation.
        a = 16'h1234; b = 16'h5678; sgn = 1'b0; start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        repeat (7) @(posedge clk);
        #1;
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        check("midrst_busy", {31'b0, busy}, 32'd0);
        check("midrst_p", p, 32'h0);
        dones = 0;
        for (int c = 0; c < 30; c++) begin
            if (done) dones++;
            @(posedge clk);
            #1;
        end
        check("midrst_no_done", 32'(dones), 32'd0);
        run_op(16'h1234, 16'h5678, 1'b0, "after_rst");
        check("after_rst_const", p, 32'h06260060);

        // Back-to-back random regression; every call after the first starts at edge k+18.
        for (int i = 0; i < 2500; i++) begin
            ra = $urandom;
            rb = $urandom;
            rs = 1'($urandom_range(0, 1));
            case ($urandom_range(0, 15))
                0: ra = '0;
                1: rb = '0;
                2: ra = 16'h8000;
                3: rb = 16'hFFFF;
                default: ;
            endcase
            run_op(ra, rb, rs, $sformatf("rand%0d", i));
        end

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end
endmodule
